prbs16_checker: RTL

- Receive-side checker for the 16-bit PRBS stream (x^16+x^15+x^13+x^4+1).
- Sits directly downstream of the PRBS16 generator, or after the channel or DUT path it drives.
- Self-synchronises to the incoming bit stream, declares lock, then counts bit errors against a locally regenerated reference.
- Tolerates an arbitrary phase and tap offset in the stream: any delayed copy of the sequence obeys the same recurrence.

---
 rtl/prbs16_checker.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/prbs16_checker.sv
// Receive-side PRBS16 (x^16+x^15+x^13+x^4+1) checker: self-synchronises,
// declares lock, then counts bit errors against a free-running local reference.
module prbs16_checker #(
    parameter int unsigned CHK_LEN  = 32,
    parameter int unsigned WIN_LEN  = 64,
    parameter int unsigned LOSS_THR = 8,
    parameter int unsigned ERR_W    = 16,
    parameter int unsigned BIT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             din,
    input  logic             clr,
    output logic             lock,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt,
    output logic [BIT_W-1:0] bit_cnt,
    output logic             sat
);

    localparam int unsigned MW  = $clog2(CHK_LEN + 1);
    localparam int unsigned WBW = $clog2(WIN_LEN + 1);
    localparam int unsigned WEW = $clog2(LOSS_THR + 1);

    typedef enum logic [1:0] {SEED, CHECK, LOCKED} state_t;

    state_t           state_q, state_d;
    logic [15:0]      ref_q, ref_d;
    logic [3:0]       seed_q, seed_d;
    logic [MW-1:0]    match_q, match_d;
    logic [WBW-1:0]   wbit_q, wbit_d;
    logic [WEW-1:0]   werr_q, werr_d;
    logic             lock_d, err_d, sat_d;
    logic [ERR_W-1:0] err_cnt_d;
    logic [BIT_W-1:0] bit_cnt_d;
    logic             p_c, m_c, bit_inc_c, err_inc_c;

    assign p_c = ref_q[15] ^ ref_q[14] ^ ref_q[12] ^ ref_q[3];
    assign m_c = en & (din != p_c);

    // Next-state, reference and window/lock bookkeeping
    always_comb begin
        state_d   = state_q;
        ref_d     = ref_q;
        seed_d    = seed_q;
        match_d   = match_q;
        wbit_d    = wbit_q;
        werr_d    = werr_q;
        bit_inc_c = 1'b0;
        err_inc_c = 1'b0;
        if (en) begin
            case (state_q)
                SEED: begin
                    ref_d = {ref_q[14:0], din};
                    if (seed_q == 4'd15) begin
                        seed_d  = 4'd0;
                        match_d = '0;
                        state_d = CHECK;
                    end else begin
                        seed_d = seed_q + 4'd1;
                    end
                end
                CHECK: begin
                    ref_d = {ref_q[14:0], din};
                    if (m_c) begin
                        match_d = '0;
                    end else if (match_q == MW'(CHK_LEN - 1)) begin
                        match_d = '0;
                        wbit_d  = '0;
                        werr_d  = '0;
                        // an all-zero reference is a stuck stream, not a lock
                        state_d = (ref_d != 16'h0000) ? LOCKED : SEED;
                    end else begin
                        match_d = match_q + MW'(1);
                    end
                end
                LOCKED: begin
                    ref_d     = {ref_q[14:0], p_c};
                    bit_inc_c = 1'b1;
                    err_inc_c = m_c;
                    if (m_c && (werr_q == WEW'(LOSS_THR - 1))) begin
                        state_d = SEED;
                        seed_d  = 4'd0;
                        wbit_d  = '0;
                        werr_d  = '0;
                    end else if (wbit_q == WBW'(WIN_LEN - 1)) begin
                        wbit_d = '0;
                        werr_d = '0;
                    end else begin
                        wbit_d = wbit_q + WBW'(1);
                        werr_d = werr_q + WEW'(m_c);
                    end
                end
                default: state_d = SEED;
            endcase
        end
    end

    // Output and statistics next values; clr has priority over increments
    always_comb begin
        lock_d    = (state_d == LOCKED);
        err_d     = m_c & (state_q == LOCKED);
        err_cnt_d = err_cnt;
        bit_cnt_d = bit_cnt;
        sat_d     = sat;
        if (clr) begin
            err_cnt_d = '0;
            bit_cnt_d = '0;
            sat_d     = 1'b0;
        end else begin
            if (bit_inc_c) begin
                if (bit_cnt != {BIT_W{1'b1}}) bit_cnt_d = bit_cnt + BIT_W'(1);
                if (bit_cnt_d == {BIT_W{1'b1}}) sat_d = 1'b1;
            end
            if (err_inc_c) begin
                if (err_cnt != {ERR_W{1'b1}}) err_cnt_d = err_cnt + ERR_W'(1);
                if (err_cnt_d == {ERR_W{1'b1}}) sat_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED;
            ref_q   <= 16'h0000;
            seed_q  <= 4'd0;
            match_q <= '0;
            wbit_q  <= '0;
            werr_q  <= '0;
            lock    <= 1'b0;
            err     <= 1'b0;
            err_cnt <= '0;
            bit_cnt <= '0;
            sat     <= 1'b0;
        end else begin
            state_q <= state_d;
            ref_q   <= ref_d;
            seed_q  <= seed_d;
            match_q <= match_d;
            wbit_q  <= wbit_d;
            werr_q  <= werr_d;
            lock    <= lock_d;
            err     <= err_d;
            err_cnt <= err_cnt_d;
            bit_cnt <= bit_cnt_d;
            sat     <= sat_d;
        end
    end

endmodule
